// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-port register-file write-back arbiter with starvation guard and a registered write stage.
// Optional saturating transfer/stall counters are built when WB_ARB_STATS_EN is defined.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        write_en,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0] stat_a_cnt,
    output logic [31:0] stat_b_cnt,
    output logic [31:0] stat_b_stall_cnt
`endif
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {PRI_A, PRI_B} state_t;

    state_t     state, state_next;
    logic [3:0] starve, starve_next;
    logic       a_xfer, b_xfer;

    // Ready may be high with its valid low; the two are mutually exclusive by construction.
    always_comb begin
        a_ready     = rst_n && !hold && (state == PRI_A ? (a_valid || !b_valid) : (a_valid && !b_valid));
        b_ready     = rst_n && !hold && (state == PRI_B ? (b_valid || !a_valid) : (b_valid && !a_valid));
        a_xfer      = a_valid && a_ready;
        b_xfer      = b_valid && b_ready;
        starve_next = hold ? starve : (b_xfer || !b_valid) ? 4'd0 : a_xfer ? starve + 4'd1 : starve;
        state_next  = hold ? state
                    : state == PRI_A ? (starve_next == STARVE_LIM ? PRI_B : PRI_A)
                    : ((b_xfer || !b_valid) ? PRI_A : PRI_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRI_A;
            starve     <= 4'd0;
            write_en   <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
        end else begin
            state    <= state_next;
            starve   <= starve_next;
            // Register 0 writes complete the handshake but never reach the register file.
            write_en <= (a_xfer && a_reg != 5'd0) || (b_xfer && b_reg != 5'd0);
            if (a_xfer) begin
                write_reg  <= a_reg;
                write_data <= a_data;
            end else if (b_xfer) begin
                write_reg  <= b_reg;
                write_data <= b_data;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_a_cnt       <= 32'd0;
            stat_b_cnt       <= 32'd0;
            stat_b_stall_cnt <= 32'd0;
        end else begin
            if (a_xfer && stat_a_cnt != '1)
                stat_a_cnt <= stat_a_cnt + 32'd1;
            if (b_xfer && stat_b_cnt != '1)
                stat_b_cnt <= stat_b_cnt + 32'd1;
            if (b_valid && !b_ready && stat_b_stall_cnt != '1)
                stat_b_stall_cnt <= stat_b_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter (STARVE_MAX=3).
// Checks the stat counters too when WB_ARB_STATS_EN is defined.
module tb_wb_port_arbiter;
    localparam int SM = 3;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        hold = 0;
    logic        a_valid = 0;
    logic        a_ready;
    logic [4:0]  a_reg = 0;
    logic [31:0] a_data = 0;
    logic        b_valid = 0;
    logic        b_ready;
    logic [4:0]  b_reg = 0;
    logic [31:0] b_data = 0;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_a_cnt, stat_b_cnt, stat_b_stall_cnt;
`endif

    wb_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data)
`ifdef WB_ARB_STATS_EN
        , .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt), .stat_b_stall_cnt(stat_b_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [37:0] sb[$];
    int          m_state = 0;
    int          m_starve = 0;
    logic [4:0]  m_reg = 0;
    logic [31:0] m_data = 0;
    logic [15:0] g_a = 0;
    logic [15:0] g_b = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_starve = 0;
        m_reg = 0;
        m_data = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_valid = 0;
        b_valid = 0;
        hold = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Drive one cycle, predict readies and the registered write, compare both.
    task automatic step(input logic h, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd);
        logic ea, eb, xa, xb;
        logic [37:0] e;
        @(negedge clk);
        hold = h; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #1;
        ea = !h && (m_state == 0 ? (av || !bv) : (av && !bv));
        eb = !h && (m_state == 1 ? (bv || !av) : (bv && !av));
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        g_a = {g_a[14:0], a_valid && a_ready};
        g_b = {g_b[14:0], b_valid && b_ready};
        xa = av && ea;
        xb = bv && eb;
        if (xa) begin m_reg = ar; m_data = ad; end
        else if (xb) begin m_reg = br; m_data = bd; end
        if (!h) begin
            m_starve = (xb || !bv) ? 0 : xa ? m_starve + 1 : m_starve;
            if (m_state == 0) m_state = (m_starve == SM) ? 1 : 0;
            else m_state = (xb || !bv) ? 0 : 1;
        end
        sb.push_back({(xa && ar != 0) || (xb && br != 0), m_reg, m_data});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("write_en", write_en, e[37]);
        check("write_reg", write_reg, e[36:32]);
        check("write_data", write_data, e[31:0]);
    endtask

    initial begin
        a_valid = 1;
        b_valid = 1;
        #13;
        check("rst_write_en", write_en, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        a_valid = 0;
        b_valid = 0;
        @(negedge clk);
        rst_n = 1;

        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check("single_a_en", write_en, 1);
        check("single_a_data", write_data, 32'hDEADBEEF);

        do_reset();
        g_a = 0; g_b = 0;
        for (int i = 0; i < 8; i++) step(0, 1, 5'(i + 1), 32'hA000 + i, 1, 5'd20, 32'hB000 + i);
        check("starve_a_pattern", g_a[7:0], 8'b1110_1110);
        check("starve_b_pattern", g_b[7:0], 8'b0001_0001);
`ifdef WB_ARB_STATS_EN
        check("stat_a_cnt", stat_a_cnt, 6);
        check("stat_b_cnt", stat_b_cnt, 2);
        check("stat_b_stall_cnt", stat_b_stall_cnt, 6);
`endif

        step(0, 0, 0, 0, 1, 5'd0, 32'h12345678);
        check("reg0_b_ready", g_b[0], 1);
        check("reg0_b_write_en", write_en, 0);
        step(0, 1, 5'd0, 32'h55AA55AA, 0, 0, 0);
        check("reg0_a_write_en", write_en, 0);

        g_a = 0; g_b = 0;
        step(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        step(0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h2);
        for (int i = 0; i < 5; i++) step(1, 1, 5'd3, 32'h10 + i, 1, 5'd4, 32'h2);
        step(0, 1, 5'd3, 32'h5, 1, 5'd4, 32'h2);
        step(0, 1, 5'd3, 32'h6, 1, 5'd4, 32'h2);
        check("hold_a_pattern", g_a[8:0], 9'b110_0000_10);
        check("hold_b_pattern", g_b[8:0], 9'b000_0000_01);

        step(0, 1, 5'd7, 32'hAAAA0001, 1, 5'd7, 32'hBBBB0001);
        check("same_dest_a_first", write_data, 32'hAAAA0001);

        // Reach PRI_B, then reset in the cycle after the A handshake.
        step(0, 1, 5'd9, 32'h91, 1, 5'd10, 32'hA1);
        step(0, 1, 5'd9, 32'h92, 1, 5'd10, 32'hA1);
        #2;
        a_valid = 0;
        b_valid = 0;
        rst_n = 0;
        #1;
        check("midrst_write_en", write_en, 0);
        check("midrst_write_reg", write_reg, 0);
        check("midrst_a_ready", a_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        g_a = 0; g_b = 0;
        for (int i = 0; i < 4; i++) step(0, 1, 5'd11, 32'hC0 + i, 1, 5'd12, 32'hD0);
        check("midrst_pattern", g_b[3:0], 4'b0001);

        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
